fibonacci_seq_ctrl: RTL
=======================

// Module: fibonacci_seq_ctrl
// PURPOSE
//  Request/response controller that sequences an iterative Fibonacci datapath.
//  Accepts an index n and steps the adder datapath once per cycle.
//  Returns Fib(n) plus an overflow flag through a valid/ready handshake.
//  Sits between a host request port and the fibonacci_step datapath; one request in flight.
// PARAMETERS
//  W      32  datapath/result width (bits, unsigned)
//  NW     6   index width; max n = 2**NW-1
//  Seed1  0   Fib(0)
//  Seed2  1   Fib(1)
// PORTS
//  clk        in   1    single clock, rising edge
//  rst        in   1    synchronous reset, active-high
//  req_valid  in   1    request present
//  req_ready  out  1    controller idle, can accept
//  req_n      in   NW   index to compute; sampled only on accept
//  rsp_valid  out  1    result available
//  rsp_ready  in   1    consumer takes result
//  rsp_fib    out  W    Fib(n): wrapped mod 2**W, or saturated (see CONFIGURATION)
//  rsp_ovf    out  1    sticky: some step exceeded W bits
//  busy       out  1    state != IDLE
// BEHAVIOUR
//  - Reset (rst high at edge): state=IDLE; rsp_valid=0, rsp_fib=0, rsp_ovf=0, busy=0.
//    req_ready = (state==IDLE) && !rst. Reset mid-CALC/DONE drops the request silently.
//  - FSM IDLE -> CALC -> DONE -> IDLE:
//    IDLE: req_ready=1. On req_valid&&req_ready: a<=Seed1, b<=Seed2, cnt<=req_n, ovf<=0.
//      n==0 -> DONE, rsp_fib<=Seed1. Otherwise -> CALC.
//    CALC: cnt==1 -> rsp_fib<=b, rsp_ovf<=ovf, -> DONE.
//      Otherwise a<=b, b<=a+b, ovf<=ovf|carry, cnt<=cnt-1.
//    DONE: rsp_valid=1; rsp_fib/rsp_ovf held stable until rsp_valid&&rsp_ready, then -> IDLE.
//  - Latency: rsp_valid is high after edge E0+n, where E0 is the accepting edge.
//    n=0 gives rsp_valid on the cycle after E0. n=1 -> E0+1.
//  - No overlap: req_ready=0 in CALC and DONE. A response handshake in DONE does not accept a
//    new request in the same cycle; the next accept is earliest one cycle later (in IDLE).
//  - req_valid/req_n are ignored outside IDLE. A held rsp_ready in CALC has no effect.
//  - Arithmetic: unsigned W-bit add; carry = bit W of the (W+1)-bit sum. rsp_ovf is sticky per request.
//  - n = 2**NW-1 is legal (cnt must not underflow). busy=1 in CALC and DONE.
// CONFIGURATION
//  Macro FIB_SAT_EN:
//   defined:   on carry, b <= {W{1'b1}} and stays saturated; rsp_fib = all-ones once overflowed.
//   undefined: b wraps mod 2**W.
//  rsp_ovf behaves identically in both builds.
// STRUCTURE
//  fibonacci_pkg: typedef enum logic [1:0] {IDLE, CALC, DONE} fib_state_e;
//   default width constants FIB_W=32, FIB_NW=6.
//  Sub-module fibonacci_step: a, b in -> next (W), carry; holds the FIB_SAT_EN mux.
//   Purely combinational; the controller owns all registers.
// TESTING
//  1 Reset: rst high 3 cycles while req_valid=1 -> rsp_valid=0, busy=0, no accept;
//    req_ready=1 the first cycle after rst drops.
//  2 n=10, rsp_ready=1 -> rsp_valid high after E0+10, rsp_fib=55, rsp_ovf=0.
//  3 n=0 and n=1 -> rsp_fib=0 at E0+0 and rsp_fib=1 at E0+1.
//  4 n=47 -> 2971215073, ovf=0. n=48 -> ovf=1 and rsp_fib=512559680 (wrap) or
//    32'hFFFF_FFFF (FIB_SAT_EN).
//  5 Backpressure: n=5, rsp_ready low 4 cycles -> rsp_fib=5 held stable, req_ready=0;
//    new req_valid (n=7) is accepted one cycle after the response handshake -> 13.
//  6 Reset mid-CALC: n=20, rst on cycle 5 -> no rsp_valid, IDLE;
//    a follow-up n=3 returns 2 with ovf=0.

Source files
------------

// File: rtl/fibonacci_pkg.sv
// fibonacci_pkg: shared FSM state type and default widths for the Fibonacci controller.
package fibonacci_pkg;
   typedef enum logic [1:0] {IDLE, CALC, DONE} fib_state_e;
   localparam int FIB_W  = 32;
   localparam int FIB_NW = 6;
endpackage

// File: rtl/fibonacci_seq_ctrl_if.sv
// fibonacci_seq_ctrl_if: request/response handshake bundle between host and controller.
interface fibonacci_seq_ctrl_if
   import fibonacci_pkg::*;
#(
   parameter int W  = FIB_W,
   parameter int NW = FIB_NW
);
   logic          req_valid;
   logic          req_ready;
   logic [NW-1:0] req_n;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [W-1:0]  rsp_fib;
   logic          rsp_ovf;
   logic          busy;
   modport master (output req_valid, req_n, rsp_ready,
                   input  req_ready, rsp_valid, rsp_fib, rsp_ovf, busy);
   modport slave  (input  req_valid, req_n, rsp_ready,
                   output req_ready, rsp_valid, rsp_fib, rsp_ovf, busy);
endinterface

// File: rtl/fibonacci_step.sv
// fibonacci_step: one combinational Fibonacci add; saturates on carry when FIB_SAT_EN is defined.
module fibonacci_step #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] next,
   output logic         carry
);
   logic [W:0] sum;
   assign sum   = {1'b0, a} + {1'b0, b};
   assign carry = sum[W];
`ifdef FIB_SAT_EN
   // once b is all-ones every later add carries, so saturation is self-sustaining
   assign next = carry ? {W{1'b1}} : sum[W-1:0];
`else
   assign next = sum[W-1:0];
`endif
endmodule

// File: rtl/fibonacci_seq_ctrl.sv
// fibonacci_seq_ctrl: single-request Fib(n) sequencer over fibonacci_step with valid/ready ports.
// Build option FIB_SAT_EN selects saturating instead of wrapping results.
module fibonacci_seq_ctrl
   import fibonacci_pkg::*;
#(
   parameter int             W     = FIB_W,
   parameter int             NW    = FIB_NW,
   parameter logic [W-1:0]   Seed1 = '0,
   parameter logic [W-1:0]   Seed2 = W'(1)
) (
   input logic          clk,
   input logic          rst,
   fibonacci_seq_ctrl_if.slave bus
);
   fib_state_e    state, state_nx;
   logic [W-1:0]  a, b, next, fib_q;
   logic [NW-1:0] cnt;
   logic          ovf, ovf_q, carry, accept, last;

   assign accept = bus.req_valid && bus.req_ready;
   assign last   = cnt == NW'(1);

   fibonacci_step #(.W(W)) u_step (.a(a), .b(b), .next(next), .carry(carry));

   always_ff @(posedge clk)
      if (rst) state <= IDLE;
      else     state <= state_nx;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    state_nx = accept ? ((bus.req_n == '0) ? DONE : CALC) : IDLE;
         CALC:    state_nx = last ? DONE : CALC;
         DONE:    state_nx = bus.rsp_ready ? IDLE : DONE;
         default: state_nx = IDLE;
      endcase
   end

   assign bus.req_ready = (state == IDLE) && !rst;
   assign bus.rsp_valid = state == DONE;
   assign bus.busy      = state != IDLE;
   assign bus.rsp_fib   = fib_q;
   assign bus.rsp_ovf   = ovf_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         a     <= '0;
         b     <= '0;
         cnt   <= '0;
         ovf   <= 1'b0;
         fib_q <= '0;
         ovf_q <= 1'b0;
      end else if (state == IDLE && accept) begin
         a   <= Seed1;
         b   <= Seed2;
         cnt <= bus.req_n;
         ovf <= 1'b0;
         if (bus.req_n == '0) begin
            fib_q <= Seed1;
            ovf_q <= 1'b0;
         end
      end else if (state == CALC) begin
         // cnt stops at 1, so n = 2**NW-1 never wraps the counter
         if (last) begin
            fib_q <= b;
            ovf_q <= ovf;
         end else begin
            a   <= b;
            b   <= next;
            ovf <= ovf | carry;
            cnt <= cnt - NW'(1);
         end
      end
   end
endmodule
